// File: rtl/regfile_pkg.sv
// Shared constants and types for the pipelined integer register file.
// Defaults match the RV32 core; instances may override widths.
package regfile_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int NREGS_DEF   = 32;
    localparam int NRPORTS_DEF = 2;
    localparam int AW_DEF      = $clog2(NREGS_DEF);
    localparam int ZERO_REG    = 0;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xdata_t;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Busy-bit scoreboard: one reservation bit per register, a running
// count of busy registers and the issue handshake that blocks WAW.
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int NREGS   = NREGS_DEF,
    parameter int NRPORTS = NRPORTS_DEF,
    parameter int BYPASS  = 1,
    parameter int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRPORTS*AW-1:0] rd_addr,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_rd,
    output logic                  issue_ready,
    output logic [NRPORTS-1:0]    rd_busy,
    output logic [AW:0]           busy_count,
    output logic                  all_idle
);

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      count_q, count_d;
    logic             set, clr, inc, dec;

    assign issue_ready = (issue_rd == ZR) || !busy_q[issue_rd]
                       || (wb_valid && wb_rd == issue_rd);

    assign set = issue_valid && issue_ready && (issue_rd != ZR);
    assign clr = wb_valid && (wb_rd != ZR);

    // Only real transitions of a bit move the count, so it always
    // equals the population of busy_q.
    assign inc = set && !busy_q[issue_rd];
    assign dec = clr && busy_q[wb_rd]
               && !(set && issue_rd == wb_rd);

    always_comb begin
        busy_d = busy_q;
        if (clr) busy_d[wb_rd] = 1'b0;
        if (set) busy_d[issue_rd] = 1'b1;
        count_d = count_q + (AW+1)'(inc) - (AW+1)'(dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_count = count_q;
    assign all_idle   = (count_q == '0);

    for (genvar p = 0; p < NRPORTS; p++) begin : g_busy
        logic [AW-1:0] a;
        assign a = rd_addr[p*AW +: AW];
        always_comb begin
            rd_busy[p] = busy_q[a];
            if (a == ZR) begin
                rd_busy[p] = 1'b0;
            end else if (BYPASS != 0 && wb_valid && wb_rd == a) begin
                rd_busy[p] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with hardwired x0, optional writeback
// bypass and an integrated busy-bit scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int NRPORTS = NRPORTS_DEF,
    parameter int BYPASS  = 1,
    parameter int AW      = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRPORTS*AW-1:0]   rd_addr,
    output logic [NRPORTS*XLEN-1:0] rd_data,
    output logic [NRPORTS-1:0]      rd_busy,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    output logic                    issue_ready,
    input  logic                    wb_valid,
    input  logic [AW-1:0]           wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    output logic [AW:0]             busy_count,
    output logic                    all_idle
);

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wb_valid && wb_rd != ZR) regs_d[wb_rd] = wb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar p = 0; p < NRPORTS; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] rdat;
        assign a = rd_addr[p*AW +: AW];
        always_comb begin
            rdat = regs_q[a];
            if (a == ZR) begin
                rdat = '0;
            end else if (BYPASS != 0 && wb_valid && wb_rd == a) begin
                rdat = wb_data;
            end
        end
        assign rd_data[p*XLEN +: XLEN] = rdat;
    end

    regfile_busy_tracker #(
        .NREGS   (NREGS),
        .NRPORTS (NRPORTS),
        .BYPASS  (BYPASS),
        .AW      (AW)
    ) u_busy (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .issue_ready (issue_ready),
        .rd_busy     (rd_busy),
        .busy_count  (busy_count),
        .all_idle    (all_idle)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: default instance (A) and a 64-bit, 16-reg,
// 4-port, no-bypass instance (B) against an array-based model.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned s_ra [2][4];
    bit          s_iv [2];
    int unsigned s_ir [2];
    bit          s_wv [2];
    int unsigned s_wr [2];
    logic [63:0] s_wd [2];

    logic [9:0]   a_rd_addr;
    logic [63:0]  a_rd_data;
    logic [1:0]   a_rd_busy;
    logic         a_ready, a_idle;
    logic [5:0]   a_cnt;

    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_ready, b_idle;
    logic [4:0]   b_cnt;

    assign a_rd_addr = {5'(s_ra[0][1]), 5'(s_ra[0][0])};
    assign b_rd_addr = {4'(s_ra[1][3]), 4'(s_ra[1][2]),
                        4'(s_ra[1][1]), 4'(s_ra[1][0])};

    regfile_sb dut_a (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (a_rd_addr),
        .rd_data     (a_rd_data),
        .rd_busy     (a_rd_busy),
        .issue_valid (s_iv[0]),
        .issue_rd    (5'(s_ir[0])),
        .issue_ready (a_ready),
        .wb_valid    (s_wv[0]),
        .wb_rd       (5'(s_wr[0])),
        .wb_data     (s_wd[0][31:0]),
        .busy_count  (a_cnt),
        .all_idle    (a_idle)
    );

    regfile_sb #(
        .XLEN    (64),
        .NREGS   (16),
        .NRPORTS (4),
        .BYPASS  (0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (b_rd_addr),
        .rd_data     (b_rd_data),
        .rd_busy     (b_rd_busy),
        .issue_valid (s_iv[1]),
        .issue_rd    (4'(s_ir[1])),
        .issue_ready (b_ready),
        .wb_valid    (s_wv[1]),
        .wb_rd       (4'(s_wr[1])),
        .wb_data     (s_wd[1]),
        .busy_count  (b_cnt),
        .all_idle    (b_idle)
    );

    // Reference model: plain arrays, one set per instance.
    logic [63:0] m_regs [2][32];
    bit          m_busy [2][32];

    typedef struct packed {
        logic [3:0][63:0] data;
        logic [3:0]       busy;
        logic             ready;
        logic [5:0]       cnt;
        logic             idle;
        logic             dsel;
    } exp_t;

    exp_t sbq [$];
    int checks = 0;
    int errors = 0;

    function automatic int nregs(int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic logic [63:0] dmask(int d);
        return (d == 0) ? 64'h0000_0000_FFFF_FFFF : '1;
    endfunction

    function automatic bit m_ready(int d);
        return s_ir[d] == 0 || !m_busy[d][s_ir[d]]
            || (s_wv[d] && s_wr[d] == s_ir[d]);
    endfunction

    function automatic exp_t expect_of(int d);
        exp_t e;
        int n;
        e = '0;
        e.dsel = (d != 0);
        for (int p = 0; p < 4; p++) begin
            int unsigned a;
            a = s_ra[d][p];
            if (a == 0) begin
                e.data[p] = '0;
                e.busy[p] = 1'b0;
            end else if (d == 0 && s_wv[d] && s_wr[d] == a) begin
                e.data[p] = s_wd[d] & dmask(d);
                e.busy[p] = 1'b0;
            end else begin
                e.data[p] = m_regs[d][a];
                e.busy[p] = m_busy[d][a];
            end
        end
        n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[d][r]);
        e.cnt   = 6'(n);
        e.idle  = (n == 0);
        e.ready = m_ready(d);
        return e;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) begin
                m_regs[d][r] = '0;
                m_busy[d][r] = 1'b0;
            end
    endtask

    task automatic commit();
        if (rst) begin
            model_clear();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            bit acc;
            acc = s_iv[d] && m_ready(d);
            if (s_wv[d] && s_wr[d] != 0) begin
                m_regs[d][s_wr[d]] = s_wd[d] & dmask(d);
                m_busy[d][s_wr[d]] = 1'b0;
            end
            if (acc && s_ir[d] != 0) m_busy[d][s_ir[d]] = 1'b1;
        end
    endtask

    task automatic apply();
        sbq.push_back(expect_of(0));
        sbq.push_back(expect_of(1));
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic set_all(bit iv, int unsigned ir, bit wv,
                           int unsigned wr, logic [63:0] wd,
                           int unsigned r0, int unsigned r1,
                           int unsigned r2, int unsigned r3);
        for (int d = 0; d < 2; d++) begin
            int unsigned m;
            m = unsigned'(nregs(d) - 1);
            s_iv[d] = iv;
            s_ir[d] = ir & m;
            s_wv[d] = wv;
            s_wr[d] = wr & m;
            s_wd[d] = wd;
            s_ra[d][0] = r0 & m;
            s_ra[d][1] = r1 & m;
            s_ra[d][2] = r2 & m;
            s_ra[d][3] = r3 & m;
        end
    endtask

    task automatic rand_stim(int d);
        int unsigned n;
        int unsigned bl [$];
        n = unsigned'(nregs(d));
        for (int r = 1; r < 32; r++) if (m_busy[d][r]) bl.push_back(r);
        s_iv[d] = ($urandom_range(0, 1) == 1);
        s_ir[d] = $urandom_range(0, n - 1);
        s_wv[d] = ($urandom_range(0, 1) == 1);
        if (bl.size() != 0 && $urandom_range(0, 3) != 0)
            s_wr[d] = bl[$urandom_range(0, bl.size() - 1)];
        else
            s_wr[d] = $urandom_range(0, n - 1);
        s_wd[d] = {$urandom, $urandom};
        for (int p = 0; p < 4; p++) s_ra[d][p] = $urandom_range(0, n - 1);
        if ($urandom_range(0, 2) == 0) s_ra[d][0] = s_wr[d];
        if ($urandom_range(0, 3) == 0) s_ir[d] = s_wr[d];
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            if (!e.dsel) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("A.rd_data%0d", p),
                        64'(a_rd_data[p*32 +: 32]), 64'(e.data[p][31:0]));
                    chk($sformatf("A.rd_busy%0d", p),
                        64'(a_rd_busy[p]), 64'(e.busy[p]));
                end
                chk("A.issue_ready", 64'(a_ready), 64'(e.ready));
                chk("A.busy_count", 64'(a_cnt), 64'(e.cnt));
                chk("A.all_idle", 64'(a_idle), 64'(e.idle));
            end else begin
                for (int p = 0; p < 4; p++) begin
                    chk($sformatf("B.rd_data%0d", p),
                        b_rd_data[p*64 +: 64], e.data[p]);
                    chk($sformatf("B.rd_busy%0d", p),
                        64'(b_rd_busy[p]), 64'(e.busy[p]));
                end
                chk("B.issue_ready", 64'(b_ready), 64'(e.ready));
                chk("B.busy_count", 64'(b_cnt), 64'(e.cnt[4:0]));
                chk("B.all_idle", 64'(b_idle), 64'(e.idle));
            end
        end
    end

    initial begin
        model_clear();
        set_all(0, 0, 0, 0, '0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        apply();

        // reservations on 5 and 9, then reset mid-traffic
        set_all(1, 5, 0, 0, '0, 5, 9, 0, 0);
        apply();
        set_all(1, 9, 1, 2, 64'h77, 5, 9, 2, 0);
        apply();
        set_all(0, 0, 0, 0, '0, 5, 9, 2, 0);
        apply();
        rst = 1'b1;
        model_clear();
        apply();
        rst = 1'b0;
        apply();

        // WAW block on 7, released by same-cycle writeback
        set_all(1, 7, 0, 0, '0, 7, 0, 0, 0);
        apply();
        set_all(1, 7, 0, 0, '0, 7, 0, 0, 0);
        apply();
        set_all(1, 7, 1, 7, 64'hDEADBEEF, 7, 0, 0, 0);
        apply();
        set_all(0, 0, 1, 7, 64'h1, 7, 0, 0, 0);
        apply();

        // bypass vs. registered read of 3
        set_all(0, 0, 1, 3, 64'h12345678, 3, 0, 0, 0);
        apply();
        set_all(0, 0, 0, 0, '0, 3, 7, 0, 0);
        apply();

        // x0 writes and reservations are ignored
        set_all(1, 0, 1, 0, 64'hFFFFFFFF_FFFFFFFF, 0, 0, 0, 0);
        apply();
        set_all(0, 0, 0, 0, '0, 0, 0, 0, 0);
        apply();

        // set of 4 with clear of 6 nets zero, then drain
        set_all(1, 6, 0, 0, '0, 6, 4, 0, 0);
        apply();
        set_all(1, 4, 1, 6, 64'h66, 6, 4, 0, 0);
        apply();
        set_all(0, 0, 1, 4, 64'h44, 6, 4, 0, 0);
        apply();
        set_all(0, 0, 0, 0, '0, 6, 4, 0, 0);
        apply();

        // four distinct per-port patterns
        set_all(0, 0, 1, 1, 64'hA5A5A5A5_A5A5A5A5, 0, 0, 0, 0);
        apply();
        set_all(0, 0, 1, 2, 64'h5A5A5A5A_5A5A5A5A, 0, 0, 0, 0);
        apply();
        set_all(0, 0, 1, 3, 64'h1, 0, 0, 0, 0);
        apply();
        set_all(0, 0, 1, 4, 64'h0, 0, 0, 0, 0);
        apply();
        set_all(0, 0, 0, 0, '0, 1, 2, 3, 4);
        apply();
        set_all(0, 0, 0, 0, '0, 3, 4, 1, 2);
        apply();

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rand_stim(0);
            rand_stim(1);
            if ($urandom_range(0, 299) == 0) begin
                s_wv[0] = 1'b0;
                s_wv[1] = 1'b0;
                rst = 1'b1;
                model_clear();
                apply();
                rst = 1'b0;
            end else begin
                apply();
            end
        end

        set_all(0, 0, 0, 0, '0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("scoreboard_drain", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
